wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order writeback stage and the

---
 rtl/rv32_pkg.sv | 11 +
 rtl/wb_port_arbiter_if.sv | 24 ++
 rtl/md_result_queue.sv | 55 +++++
 rtl/wb_port_arbiter.sv | 54 +++++
 tb/tb_wb_port_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared register-file widths and the MDU result-queue entry type
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } mdEntryT;
  localparam int ENTRY_W = $bits(mdEntryT);
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback/MDU requests in, register-file write port and hazard signals out
interface wb_port_arbiter_if;
  import rv32_pkg::*;
  logic RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0] ResultW;
  logic MdValid;
  logic [REG_ADDR_W-1:0] MdRd;
  logic [XLEN-1:0] MdResult;
  logic MdReady;
  logic RegWriteRF;
  logic [REG_ADDR_W-1:0] RdRF;
  logic [XLEN-1:0] WDRF;
  logic StallWB;
  logic [XLEN-1:0] PendingMask;
  modport master (
    output RegWriteW, RdW, ResultW, MdValid, MdRd, MdResult,
    input MdReady, RegWriteRF, RdRF, WDRF, StallWB, PendingMask
  );
  modport slave (
    input RegWriteW, RdW, ResultW, MdValid, MdRd, MdResult,
    output MdReady, RegWriteRF, RdRF, WDRF, StallWB, PendingMask
  );
endinterface

// File: rtl/md_result_queue.sv
// md_result_queue: in-order MDU result FIFO with kill-by-rd, auto-pop of killed heads and pending mask
module md_result_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [REG_ADDR_W-1:0] pushRd,
  input  logic [XLEN-1:0] pushData,
  input  logic serve,
  input  logic kill,
  input  logic [REG_ADDR_W-1:0] killRd,
  output logic empty,
  output logic full,
  output logic headValid,
  output logic pop,
  output logic [REG_ADDR_W-1:0] headRd,
  output logic [XLEN-1:0] headData,
  output logic [XLEN-1:0] pendingMask
);
  localparam int PW = $clog2(DEPTH);
  mdEntryT q [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0] count;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign headValid = !empty && q[rdPtr].valid;
  assign headRd = q[rdPtr].rd;
  assign headData = q[rdPtr].data;
  assign pop = !empty && (!q[rdPtr].valid || serve);
  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q[i].valid) pendingMask[q[i].rd] = 1'b1;
    pendingMask[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && q[i].rd == killRd) q[i].valid <= 1'b0;
      if (pop) q[rdPtr].valid <= 1'b0;
      if (push) q[wrPtr] <= '{valid: 1'b1, rd: pushRd, data: pushData};
      rdPtr <= rdPtr + PW'(pop);
      wrPtr <= wrPtr + PW'(push);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and queued/bypassed MDU results
module wb_port_arbiter
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  wb_port_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic pwr, acc, bypass, push, serve, empty, full, headValid, pop;
  logic [REG_ADDR_W-1:0] headRd;
  logic [XLEN-1:0] headData;
  logic [WW-1:0] waitCnt, waitNext;
  assign pwr = bus.RegWriteW && bus.RdW != '0;
  assign bus.MdReady = !full;
  assign acc = bus.MdValid && !full && !rst;
  assign serve = headValid && !pwr && !rst;
  assign bypass = empty && acc && bus.MdRd != '0 && !pwr;
  // a pipeline write to the same rd is younger, so the MDU result is dead on arrival
  assign push = acc && bus.MdRd != '0 && !bypass && !(pwr && bus.MdRd == bus.RdW);
  assign bus.RegWriteRF = pwr || serve || bypass;
  assign bus.RdRF = pwr ? bus.RdW : serve ? headRd : bypass ? bus.MdRd : '0;
  assign bus.WDRF = pwr ? bus.ResultW : serve ? headData : bypass ? bus.MdResult : '0;
  assign waitNext = (pop || empty) ? '0 : (headValid && waitCnt != WW'(MAX_WAIT)) ? waitCnt + 1'b1 : waitCnt;
  md_result_queue #(.DEPTH(DEPTH)) queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pushRd(bus.MdRd),
    .pushData(bus.MdResult),
    .serve(serve),
    .kill(pwr),
    .killRd(bus.RdW),
    .empty(empty),
    .full(full),
    .headValid(headValid),
    .pop(pop),
    .headRd(headRd),
    .headData(headData),
    .pendingMask(bus.PendingMask)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
      bus.StallWB <= 1'b0;
    end else begin
      waitCnt <= waitNext;
      bus.StallWB <= waitNext == WW'(MAX_WAIT);
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a scoreboard of expected register-file writes
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [36:0] expQ [$];
  wb_port_arbiter_if bus ();
  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.RegWriteRF === 1'b1) begin
      logic [36:0] e;
      tests++;
      if (expQ.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got x%0d=%h, required no write", bus.RdRF, bus.WDRF);
      end else begin
        e = expQ.pop_front();
        if ({bus.RdRF, bus.WDRF} !== e) begin
          fails++;
          $display("FAIL port_write: got x%0d=%h, required x%0d=%h", bus.RdRF, bus.WDRF, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
    bus.RegWriteW = rw;
    bus.RdW = rd;
    bus.ResultW = res;
    bus.MdValid = mv;
    bus.MdRd = mrd;
    bus.MdResult = mres;
    #2;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [4:0] rd, input logic [31:0] d);
    expQ.push_back({rd, d});
  endtask

  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    nxt();
    nxt();
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_mdready", {31'd0, bus.MdReady}, 32'd1);
    chk("reset_stall", {31'd0, bus.StallWB}, 32'd0);
    chk("reset_mask", bus.PendingMask, 32'd0);
    chk("reset_regwrite", {31'd0, bus.RegWriteRF}, 32'd0);
    nxt();
    // idle port bypass
    expw(5, 32'hDEADBEEF);
    cyc(0, 0, 0, 1, 5, 32'hDEADBEEF);
    chk("bypass_mask", bus.PendingMask, 32'd0);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    chk("bypass_mask_after", bus.PendingMask, 32'd0);
    nxt();
    // collision: pipeline wins, MDU result next cycle
    expw(3, 32'h11);
    expw(7, 32'h22);
    cyc(1, 3, 32'h11, 1, 7, 32'h22);
    chk("coll_mask0", bus.PendingMask, 32'd0);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    chk("coll_mask1", bus.PendingMask, 32'h80);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    chk("coll_mask2", bus.PendingMask, 32'd0);
    nxt();
    // full queue, held third result
    expw(1, 32'h100);
    cyc(1, 1, 32'h100, 1, 8, 32'h808);
    chk("full_ready0", {31'd0, bus.MdReady}, 32'd1);
    nxt();
    expw(1, 32'h101);
    cyc(1, 1, 32'h101, 1, 9, 32'h909);
    chk("full_ready1", {31'd0, bus.MdReady}, 32'd1);
    nxt();
    expw(1, 32'h102);
    cyc(1, 1, 32'h102, 1, 10, 32'hA0A);
    chk("full_ready2", {31'd0, bus.MdReady}, 32'd0);
    chk("full_mask", bus.PendingMask, 32'h300);
    nxt();
    expw(8, 32'h808);
    cyc(0, 0, 0, 1, 10, 32'hA0A);
    chk("drain_ready0", {31'd0, bus.MdReady}, 32'd0);
    nxt();
    expw(9, 32'h909);
    cyc(0, 0, 0, 1, 10, 32'hA0A);
    chk("drain_ready1", {31'd0, bus.MdReady}, 32'd1);
    nxt();
    expw(10, 32'hA0A);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_mask", bus.PendingMask, 32'h400);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_empty", bus.PendingMask, 32'd0);
    nxt();
    // WAW kill of a queued entry
    expw(2, 32'h22);
    cyc(1, 2, 32'h22, 1, 12, 32'hAA);
    nxt();
    expw(12, 32'hBB);
    cyc(1, 12, 32'hBB, 0, 0, 0);
    chk("kill_mask_before", bus.PendingMask, 32'h1000);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    chk("kill_mask_after", bus.PendingMask, 32'd0);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    nxt();
    // starvation
    expw(2, 32'h33);
    cyc(1, 2, 32'h33, 1, 20, 32'h1414);
    nxt();
    for (int k = 1; k <= 6; k++) begin
      expw(3, 32'h40 + k);
      cyc(1, 3, 32'h40 + k, 0, 0, 0);
      chk($sformatf("stall_k%0d", k), {31'd0, bus.StallWB}, {31'd0, k >= 5});
      nxt();
    end
    expw(20, 32'h1414);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_on_pop", {31'd0, bus.StallWB}, 32'd1);
    nxt();
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_released", {31'd0, bus.StallWB}, 32'd0);
    nxt();
    // reset with two entries queued
    expw(1, 32'h50);
    cyc(1, 1, 32'h50, 1, 21, 32'h15);
    nxt();
    expw(1, 32'h51);
    cyc(1, 1, 32'h51, 1, 22, 32'h16);
    nxt();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("prerst_mask", bus.PendingMask, 32'h0060_0000);
    chk("prerst_ready", {31'd0, bus.MdReady}, 32'd0);
    nxt();
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_mask", bus.PendingMask, 32'd0);
    chk("rst_ready", {31'd0, bus.MdReady}, 32'd1);
    chk("rst_stall", {31'd0, bus.StallWB}, 32'd0);
    for (int i = 0; i < 4; i++) nxt();
    chk("scoreboard_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
